// File: rtl/pipelined_wb_cache.sv
// 2-stage pipelined set-associative write-back/write-allocate cache with tree-PLRU replacement.
// Optional hit/miss/writeback counters are enabled by defining PCACHE_PERF_CNT_EN.
module pipelined_wb_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill,
    input  logic [31:0]             ufp_addr,
    input  logic [3:0]              ufp_rmask,
    input  logic [3:0]              ufp_wmask,
    input  logic [31:0]             ufp_wdata,
    output logic                    ufp_ready,
    output logic [31:0]             ufp_rdata,
    output logic                    ufp_resp,
    output logic [31:0]             dfp_addr,
    output logic                    dfp_read,
    output logic                    dfp_write,
    output logic [8*LINE_BYTES-1:0] dfp_wdata,
    input  logic [8*LINE_BYTES-1:0] dfp_rdata,
    input  logic                    dfp_resp
`ifdef PCACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt,
    output logic [31:0]             wb_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - SET_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORD_W = OFF_W - 2;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t                          state_q, state_d;
    logic                            stage_valid_q, stage_valid_d;
    logic [31:0]                     stage_addr_q, stage_addr_d;
    logic [3:0]                      stage_wmask_q, stage_wmask_d;
    logic [31:0]                     stage_wdata_q, stage_wdata_d;
    logic                            kill_pend_q, kill_pend_d;
    logic [WAY_W-1:0]                victim_q, victim_d;
    logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-2:0]       plru_q, plru_d;

    logic [SET_W-1:0]                set_idx;
    logic [TAG_W-1:0]                req_tag;
    logic [WORD_W-1:0]               word_idx;
    logic [WAYS-1:0][LINE_W-1:0]     way_line;
    logic [WAYS-1:0][TAG_W-1:0]      way_tag;
    logic [WAYS-1:0]                 way_hit;
    logic [WAYS-1:0]                 way_we;
    logic [LINE_W-1:0]               wr_line, merged_line;
    logic                            hit;
    logic [WAY_W-1:0]                hit_way, victim_sel;
    logic [WAYS-2:0]                 plru_upd;

    assign set_idx  = stage_addr_q[OFF_W +: SET_W];
    assign req_tag  = stage_addr_q[31 -: TAG_W];
    assign word_idx = stage_addr_q[2 +: WORD_W];

    // All array traffic (lookup, write hit, fill) is addressed by the stage register's set.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [LINE_W-1:0] data_mem [SETS];
            logic [TAG_W-1:0]  tag_mem  [SETS];
            always_ff @(posedge clk) begin
                if (way_we[gi]) begin
                    data_mem[set_idx] <= wr_line;
                    tag_mem[set_idx]  <= req_tag;
                end
            end
            assign way_line[gi] = data_mem[set_idx];
            assign way_tag[gi]  = tag_mem[set_idx];
            assign way_hit[gi]  = valid_q[set_idx][gi] && (tag_mem[set_idx] == req_tag);
        end
    endgenerate

    always_comb begin
        int node;
        hit     = stage_valid_q && (|way_hit);
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
        node = 1;
        for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(plru_q[set_idx][node-1]);
        victim_sel = WAY_W'(node - WAYS);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) victim_sel = WAY_W'(w);
        end
        // Each node on the hit path is pointed at the sibling subtree.
        plru_upd = plru_q[set_idx];
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            plru_upd[node-1] = ~hit_way[WAY_W-1-l];
            node = 2 * node + int'(hit_way[WAY_W-1-l]);
        end
        merged_line = way_line[hit_way];
        for (int b = 0; b < 4; b++) begin
            if (stage_wmask_q[b])
                merged_line[32*int'(word_idx) + 8*b +: 8] = stage_wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        state_d       = state_q;
        stage_valid_d = stage_valid_q;
        stage_addr_d  = stage_addr_q;
        stage_wmask_d = stage_wmask_q;
        stage_wdata_d = stage_wdata_q;
        kill_pend_d   = kill_pend_q;
        victim_d      = victim_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        plru_d        = plru_q;
        way_we        = '0;
        wr_line       = merged_line;
        ufp_ready     = 1'b0;
        ufp_resp      = 1'b0;
        ufp_rdata     = way_line[hit_way][32*int'(word_idx) +: 32];
        dfp_read      = 1'b0;
        dfp_write     = 1'b0;
        dfp_addr      = {req_tag, set_idx, OFF_W'(0)};
        dfp_wdata     = way_line[victim_q];
        case (state_q)
            COMPARE: begin
                ufp_ready = !(stage_valid_q && !hit);
                if (kill) begin
                    stage_valid_d = 1'b0;
                end else if (stage_valid_q && !hit) begin
                    victim_d    = victim_sel;
                    kill_pend_d = 1'b0;
                    state_d     = (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel])
                                  ? WRITEBACK : ALLOCATE;
                end else begin
                    if (hit) begin
                        ufp_resp        = 1'b1;
                        plru_d[set_idx] = plru_upd;
                        if (|stage_wmask_q) begin
                            way_we[hit_way]           = 1'b1;
                            dirty_d[set_idx][hit_way] = 1'b1;
                        end
                    end
                    stage_valid_d = |(ufp_rmask | ufp_wmask);
                    stage_addr_d  = ufp_addr;
                    stage_wmask_d = ufp_wmask;
                    stage_wdata_d = ufp_wdata;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {way_tag[victim_q], set_idx, OFF_W'(0)};
                if (kill) kill_pend_d = 1'b1;
                if (dfp_resp) begin
                    if (kill || kill_pend_q) begin
                        state_d       = COMPARE;
                        stage_valid_d = 1'b0;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                if (kill) kill_pend_d = 1'b1;
                if (dfp_resp) begin
                    wr_line                    = dfp_rdata;
                    way_we[victim_q]           = 1'b1;
                    valid_d[set_idx][victim_q] = 1'b1;
                    dirty_d[set_idx][victim_q] = 1'b0;
                    if (kill || kill_pend_q) begin
                        state_d       = COMPARE;
                        stage_valid_d = 1'b0;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            default: begin
                state_d = COMPARE;
                if (kill) stage_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COMPARE;
            stage_valid_q <= 1'b0;
            kill_pend_q   <= 1'b0;
            valid_q       <= '0;
            dirty_q       <= '0;
            plru_q        <= '0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            kill_pend_q   <= kill_pend_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            plru_q        <= plru_d;
        end
        stage_addr_q  <= stage_addr_d;
        stage_wmask_q <= stage_wmask_d;
        stage_wdata_q <= stage_wdata_d;
        victim_q      <= victim_d;
    end

`ifdef PCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (ufp_resp && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == COMPARE && (state_d == ALLOCATE || state_d == WRITEBACK)
            && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        if (state_q == WRITEBACK && dfp_resp && wb_cnt_q != 32'hFFFF_FFFF) wb_cnt_d = wb_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_pipelined_wb_cache.sv
// Scoreboard bench for pipelined_wb_cache: a flat reference memory predicts read data,
// a latency-controlled memory model serves line reads/writes and logs dfp traffic.
module tb_pipelined_wb_cache;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst, kill;
    logic [31:0]   ufp_addr, ufp_wdata, ufp_rdata, dfp_addr;
    logic [3:0]    ufp_rmask, ufp_wmask;
    logic          ufp_ready, ufp_resp, dfp_read, dfp_write, dfp_resp;
    logic [LW-1:0] dfp_wdata, dfp_rdata;
`ifdef PCACHE_PERF_CNT_EN
    logic [31:0]   hit_cnt, miss_cnt, wb_cnt;
`endif

    pipelined_wb_cache #(.WAYS(4), .SETS(16), .LINE_BYTES(32)) dut (
        .clk(clk), .rst(rst), .kill(kill),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask), .ufp_wdata(ufp_wdata),
        .ufp_ready(ufp_ready), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
`ifdef PCACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {bit is_rd; logic [31:0] addr; logic [31:0] data;} sb_t;
    typedef struct {bit wr; logic [31:0] addr;} dl_t;

    sb_t         sb_q[$];
    dl_t         dlog[$];
    sb_t         mon_e;
    int          resp_cyc[$];
    logic [31:0] ref_mem [int unsigned];
    logic [LW-1:0] bk_mem [int unsigned];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, resp_count = 0, rd_cnt = 0, wr_cnt = 0, busy = 0, mem_lat = 2;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
        return init_word(a);
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [31:0] la);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_word(la + 32'(4*i));
        return l;
    endfunction

    function automatic logic [LW-1:0] bk_line(input logic [31:0] la);
        logic [LW-1:0] l;
        if (bk_mem.exists(la >> 5)) return bk_mem[la >> 5];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(la + 32'(4*i));
        return l;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        sb_t e;
        logic [31:0] w;
        int n = 0;
        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        @(negedge clk);
        while (!ufp_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq("ready_timeout", 0, 1);
        if (wm != 0) begin
            w = ref_word(a);
            for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a >> 2] = w;
        end
        e.is_rd = (rm != 0);
        e.addr  = a;
        e.data  = ref_word(a);
        sb_q.push_back(e);
        @(posedge clk); #1;
        ufp_rmask = '0; ufp_wmask = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) check_eq("drain_timeout", sb_q.size(), 0);
        #1;
    endtask

    task automatic wait_dfp_read();
        int n = 0;
        @(negedge clk);
        while (!dfp_read && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("dfp_read_timeout", 0, 1);
    endtask

    task automatic check_log(input string tag, input int idx, input bit wr, input logic [31:0] a);
        if (idx < dlog.size()) check_eq(tag, {dlog[idx].wr, dlog[idx].addr}, {wr, a});
        else check_eq({tag, "_missing"}, dlog.size(), idx + 1);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && ufp_resp) begin
            resp_cyc.push_back(cyc);
            resp_count++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_rd) check_eq($sformatf("rdata@%h", mon_e.addr), ufp_rdata, mon_e.data);
            end
        end
    end

    // Memory model: answers after mem_lat cycles of a held request.
    initial begin
        dfp_resp = 1'b0;
        dfp_rdata = '0;
        forever begin
            @(negedge clk);
            dfp_resp = 1'b0;
            if (rst) begin
                busy = 0;
            end else begin
                if (busy != 0) check_eq("dfp_held", dfp_read | dfp_write, 1);
                if (dfp_read | dfp_write) begin
                    check_eq("dfp_rw_excl", dfp_read & dfp_write, 0);
                    busy++;
                    if (busy >= mem_lat) begin
                        if (dfp_write) begin
                            check_eq($sformatf("wb_line@%h", dfp_addr), dfp_wdata, ref_line(dfp_addr));
                            bk_mem[dfp_addr >> 5] = dfp_wdata;
                            wr_cnt++;
                        end else begin
                            dfp_rdata = bk_line(dfp_addr);
                            rd_cnt++;
                        end
                        dlog.push_back('{dfp_write, dfp_addr});
                        dfp_resp = 1'b1;
                        busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, rc;
        rst = 1'b1; kill = 1'b0;
        ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", ufp_ready, 1);
        check_eq("rst_resp", ufp_resp, 0);
        check_eq("rst_dfp", {dfp_read, dfp_write}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold read fills line 0x1000 and returns word 1.
        mark = dlog.size();
        issue(32'h1004, 4'hF, 4'h0, '0);
        drain();
        check_eq("cold_dfp_count", dlog.size() - mark, 1);
        check_log("cold_dfp_read", mark, 1'b0, 32'h1000);

        // Back-to-back hits at one per cycle.
        mark = dlog.size();
        rc = resp_cyc.size();
        issue(32'h1000, 4'hF, 4'h0, '0);
        issue(32'h1004, 4'hF, 4'h0, '0);
        issue(32'h1008, 4'hF, 4'h0, '0);
        drain();
        check_eq("b2b_no_dfp", dlog.size() - mark, 0);
        check_eq("b2b_resp_count", resp_cyc.size() - rc, 3);
        if (resp_cyc.size() >= rc + 3) begin
            check_eq("b2b_gap1", resp_cyc[rc+1] - resp_cyc[rc], 1);
            check_eq("b2b_gap2", resp_cyc[rc+2] - resp_cyc[rc+1], 1);
        end

        // Byte-masked write hit then read back.
        issue(32'h1000, 4'h0, 4'b0011, 32'hDEAD_BEEF);
        issue(32'h1000, 4'hF, 4'h0, '0);
        drain();

        // Fill ways 1..3 of set 0, then a fifth tag evicts dirty way 0.
        issue(32'h1200, 4'hF, 4'h0, '0); drain();
        issue(32'h1400, 4'hF, 4'h0, '0); drain();
        issue(32'h1600, 4'hF, 4'h0, '0); drain();
        mark = dlog.size();
        issue(32'h1800, 4'hF, 4'h0, '0);
        drain();
        check_eq("evict_dfp_count", dlog.size() - mark, 2);
        check_log("evict_wb", mark, 1'b1, 32'h1000);
        check_log("evict_fill", mark + 1, 1'b0, 32'h1800);

        // Re-fetching 0x1000 now evicts a clean way: read only, data carries the written bytes.
        mark = dlog.size();
        issue(32'h1000, 4'hF, 4'h0, '0);
        drain();
        check_eq("refetch_dfp_count", dlog.size() - mark, 1);
        check_log("refetch_read", mark, 1'b0, 32'h1000);

        // Kill during ALLOCATE; fill completes, no response, then the line hits.
        mem_lat = 4;
        mark = dlog.size();
        rc = resp_cyc.size();
        issue(32'h2020, 4'hF, 4'h0, '0);
        wait_dfp_read();
        if (sb_q.size() != 0) sb_q.delete(sb_q.size() - 1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!(ufp_ready && !dfp_read) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check_eq("kill_ready_timeout", 0, 1);
        end
        @(posedge clk); #1;
        mem_lat = 2;
        check_eq("kill_no_resp", resp_cyc.size() - rc, 0);
        check_eq("kill_dfp_count", dlog.size() - mark, 1);
        check_log("kill_fill", mark, 1'b0, 32'h2020);
        mark = dlog.size();
        issue(32'h2024, 4'hF, 4'h0, '0);
        drain();
        check_eq("kill_then_hit_no_dfp", dlog.size() - mark, 0);

`ifdef PCACHE_PERF_CNT_EN
        check_eq("perf_hit", hit_cnt, resp_count);
        check_eq("perf_miss", miss_cnt, rd_cnt);
        check_eq("perf_wb", wb_cnt, wr_cnt);
`endif

        // Reset in the middle of a line read.
        issue(32'h3000, 4'hF, 4'h0, '0);
        wait_dfp_read();
        if (sb_q.size() != 0) sb_q.delete(sb_q.size() - 1);
        rst = 1'b1;
        resp_count = 0; rd_cnt = 0; wr_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_dfp", {dfp_read, dfp_write}, 2'b00);
        check_eq("midrst_ready", ufp_ready, 1);
        check_eq("midrst_resp", ufp_resp, 0);
`ifdef PCACHE_PERF_CNT_EN
        check_eq("perf_rst_clear", {hit_cnt, miss_cnt, wb_cnt}, 96'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Valid bits were cleared: the previously cached line misses again.
        mark = dlog.size();
        issue(32'h1000, 4'hF, 4'h0, '0);
        drain();
        check_eq("post_rst_dfp_count", dlog.size() - mark, 1);
        check_log("post_rst_read", mark, 1'b0, 32'h1000);
`ifdef PCACHE_PERF_CNT_EN
        check_eq("perf_post_hit", hit_cnt, 1);
        check_eq("perf_post_miss", miss_cnt, 1);
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
